// File: rtl/bus_store_pkg.sv
// Shared types and constants for the AXI store-bus write-channel arbiter.
package bus_store_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } store_arb_state_t;

  localparam logic MASTER0_ID = 1'b0;
  localparam logic MASTER1_ID = 1'b1;

  localparam int BEAT_CNT_W = 5;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = 5'd16;

  // Number of W beats an AW with the given awlen announces (awlen + 1).
  function automatic logic [BEAT_CNT_W-1:0] beats_expected(input logic [3:0] len);
    return {1'b0, len} + 5'd1;
  endfunction

endpackage

// File: rtl/bus_store_rr_pick.sv
// Combinational winner selection between the two store masters.
module bus_store_rr_pick
  import bus_store_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_id,
  input  logic i_rr,
  output logic o_id,
  output logic o_valid
);

  // A contested round goes to the master that did not win last time when
  // round-robin is on; otherwise master0 always wins a contest.
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_id    = MASTER0_ID;
    if (i_req0 && i_req1) begin
      o_id = i_rr ? ~i_last_id : MASTER0_ID;
    end else if (i_req1) begin
      o_id = MASTER1_ID;
    end
  end

endmodule

// File: rtl/bus_store_arbiter.sv
// Write-channel arbiter: grants one master for a whole AXI3 write (AW, W*, B)
// and flags a burst whose W beat count disagrees with awlen.
module bus_store_arbiter
  import bus_store_pkg::*;
#(
  parameter bit RR = 1'b1
)
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       m0_awvalid,
  input  logic       m1_awvalid,
  input  logic       awvalid,
  input  logic       awready,
  input  logic [3:0] awlen,
  input  logic       wvalid,
  input  logic       wready,
  input  logic       wlast,
  input  logic       bvalid,
  input  logic       bready,
  output logic       m0_grnt,
  output logic       m1_grnt,
  output logic       busy,
  output logic       wr_err,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_XFER = XFER;
  localparam logic [1:0] ST_RESP = RESP;

  // Handshakes: a beat on any channel transfers in the cycle where its valid
  // and ready are both high at the rising edge; valid alone means nothing.
  logic w_aw_hs;
  logic w_w_hs;
  logic w_wlast_hs;
  logic w_b_hs;

  logic                  w_pick_id;
  logic                  w_pick_valid;
  logic                  w_beat_sat;
  logic [BEAT_CNT_W-1:0] w_beat_next;
  logic                  w_ovf_next;
  logic [3:0]            w_len_eff;
  logic                  w_len_err;
  logic                  w_xfer_done;

  logic [1:0]            r_state;
  logic                  r_m0_grnt;
  logic                  r_m1_grnt;
  logic                  r_wr_err;
  logic                  r_last_id;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [3:0]            r_len_q;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic                  r_beat_ovf;

  assign w_aw_hs    = awvalid & awready;
  assign w_w_hs     = wvalid & wready;
  assign w_wlast_hs = w_w_hs & wlast;
  assign w_b_hs     = bvalid & bready;

  bus_store_rr_pick u_pick (
    .i_req0    (m0_awvalid),
    .i_req1    (m1_awvalid),
    .i_last_id (r_last_id),
    .i_rr      (RR),
    .o_id      (w_pick_id),
    .o_valid   (w_pick_valid)
  );

  // Beat counting saturates at 16; any beat beyond that is remembered so the
  // burst is still reported even if the saturated count happens to match.
  always_comb begin
    w_beat_sat  = (r_beat_cnt == BEAT_CNT_MAX);
    w_beat_next = r_beat_cnt;
    if (w_w_hs && !w_beat_sat) begin
      w_beat_next = r_beat_cnt + 5'd1;
    end
    w_ovf_next  = r_beat_ovf | (w_w_hs & w_beat_sat);
    w_len_eff   = r_aw_done ? r_len_q : awlen;
    w_len_err   = w_ovf_next | (w_beat_next != beats_expected(w_len_eff));
    w_xfer_done = (r_state == ST_XFER)
                & (r_aw_done | w_aw_hs)
                & (r_w_done | w_wlast_hs);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_m0_grnt <= 1'b0;
      r_m1_grnt <= 1'b0;
      r_wr_err  <= 1'b0;
      r_last_id <= MASTER1_ID;
    end else begin
      r_wr_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state   <= ST_XFER;
            r_m0_grnt <= (w_pick_id == MASTER0_ID);
            r_m1_grnt <= (w_pick_id == MASTER1_ID);
            r_last_id <= w_pick_id;
          end
        end
        ST_XFER: begin
          if (w_xfer_done) begin
            r_state  <= ST_RESP;
            r_wr_err <= w_len_err;
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_state   <= ST_IDLE;
            r_m0_grnt <= 1'b0;
            r_m1_grnt <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_m0_grnt <= 1'b0;
          r_m1_grnt <= 1'b0;
        end
      endcase
    end
  end

  // AW/W progress of the granted transaction; W may finish before AW.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_len_q    <= 4'd0;
      r_beat_cnt <= '0;
      r_beat_ovf <= 1'b0;
    end else if (r_state == ST_XFER) begin
      if (w_xfer_done) begin
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        r_beat_cnt <= '0;
        r_beat_ovf <= 1'b0;
      end else begin
        if (w_aw_hs && !r_aw_done) begin
          r_aw_done <= 1'b1;
          r_len_q   <= awlen;
        end
        if (w_wlast_hs) begin
          r_w_done <= 1'b1;
        end
        r_beat_cnt <= w_beat_next;
        r_beat_ovf <= w_ovf_next;
      end
    end
  end

  assign m0_grnt   = r_m0_grnt;
  assign m1_grnt   = r_m1_grnt;
  assign busy      = (r_state != ST_IDLE);
  assign wr_err    = r_wr_err;
  assign dbg_state = r_state;

endmodule
